// File: rtl/fifo_pkt_rr_drain_if.sv
// Output beat stream of the packet drain scheduler.
//   tvalid  beat valid (driven by master)
//   tready  downstream accept (driven by slave)
//   tdata   beat payload
//   tlast   last beat of the packet
//   tdest   index of the FIFO channel the beat came from
interface fifo_pkt_rr_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_W       = 2
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic [CH_W-1:0]       tdest;

  modport master (output tvalid, output tdata, output tlast, output tdest, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tdest, output tready);
endinterface

// File: rtl/fifo_pkt_rr_drain.sv
// Read-side packet scheduler for N_CH FIFOs sharing one output stream.
// Grants one channel at a time in round-robin order, drains exactly one
// tlast-delimited packet from it, then re-arbitrates.
//   m_clk, m_rst_n  clock and asynchronous active-low reset
//   ch_en           per-channel arbitration enable
//   ch_empty        FIFO empty flags
//   ch_rd_en        FIFO read enables (at most one high)
//   ch_tdata        FIFO read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH],
//                   valid the cycle after that channel's rd_en
//   ch_tlast        FIFO read tlast, same timing as ch_tdata
//   out             registered output stream tagged with source channel
//   busy            high while a packet is locked
//   pkt_done        one-cycle pulse with the tlast beat's out.tvalid rise
module fifo_pkt_rr_drain #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CH_W       = $clog2(N_CH)
) (
  input  logic                       m_clk,
  input  logic                       m_rst_n,
  input  logic [N_CH-1:0]            ch_en,
  input  logic [N_CH-1:0]            ch_empty,
  output logic [N_CH-1:0]            ch_rd_en,
  input  logic [N_CH*DATA_WIDTH-1:0] ch_tdata,
  input  logic [N_CH-1:0]            ch_tlast,
  fifo_pkt_rr_drain_if.master        out,
  output logic                       busy,
  output logic                       pkt_done
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                  state;
  logic [CH_W-1:0]         grant;
  logic [CH_W-1:0]         rr_ptr;
  logic                    rd_vld_p1;
  logic                    issue_p0;
  logic                    sel_empty;
  logic [DATA_WIDTH-1:0]   sel_data_p1;
  logic                    sel_last_p1;
  logic [CH_W:0]           pick;

  // Round-robin search starting one past ptr. Scanning from the far end and
  // overwriting leaves the nearest candidate, so no early exit is needed.
  // Result MSB flags that a candidate was found.
  function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] req,
                                            input logic [CH_W-1:0] ptr);
    logic [CH_W:0] res;
    int            idx;
    res = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_CH;
      if (req[idx]) res = {1'b1, CH_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    pick        = rr_pick(ch_en & ~ch_empty, rr_ptr);
    sel_empty   = 1'b1;
    sel_data_p1 = '0;
    sel_last_p1 = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CH_W'(i)) begin
        sel_empty   = ch_empty[i];
        sel_data_p1 = ch_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last_p1 = ch_tlast[i];
      end
    end
  end

  // p0: read issue. Only one read in flight, and only when the output slot
  // is guaranteed free at capture time, so a beat can never be dropped.
  assign issue_p0 = (state == XFER) && !sel_empty && !rd_vld_p1 &&
                    (!out.tvalid || out.tready);

  always_comb begin
    ch_rd_en = '0;
    for (int i = 0; i < N_CH; i++) ch_rd_en[i] = issue_p0 && (grant == CH_W'(i));
  end

  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= CH_W'(N_CH - 1);
      rd_vld_p1  <= 1'b0;
      busy       <= 1'b0;
      pkt_done   <= 1'b0;
      out.tvalid <= 1'b0;
      out.tdata  <= '0;
      out.tlast  <= 1'b0;
      out.tdest  <= '0;
    end else begin
      pkt_done  <= 1'b0;
      rd_vld_p1 <= issue_p0;

      // p1: FIFO data returns and is captured into the output register.
      // A capture in the same cycle as an accept reloads and keeps tvalid high.
      if (rd_vld_p1) begin
        out.tdata  <= sel_data_p1;
        out.tlast  <= sel_last_p1;
        out.tdest  <= grant;
        out.tvalid <= 1'b1;
      end else if (out.tvalid && out.tready) begin
        out.tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick[CH_W]) begin
            grant  <= pick[CH_W-1:0];
            rr_ptr <= pick[CH_W-1:0];
            state  <= XFER;
            busy   <= 1'b1;
          end
        end
        XFER: begin
          // Lock is released only by tlast; ch_en and ch_empty changes on the
          // granted channel merely stall reads.
          if (rd_vld_p1 && sel_last_p1) begin
            pkt_done <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_pkt_rr_drain.md
# fifo_pkt_rr_drain

Read-side packet scheduler for up to N_CH asynchronous FIFOs sharing one output stream. It sits entirely in the m_clk domain and drives each FIFO's read port (rd_en/empty, registered m_tdata/m_tlast). It grants one channel at a time in round-robin order and drains exactly one tlast-delimited packet from it before re-arbitrating. Beats go out on a single valid/ready stream tagged with the source channel index.

## Interface
- N_CH, 4: number of FIFO channels (2..16).
- DATA_WIDTH, 8: beat width; must match the FIFOs.
- CH_W, $clog2(N_CH): derived; width of channel index. Not overridden.
- m_clk  in  1  read-domain clock; all logic is on its rising edge.
- m_rst_n  in  1  asynchronous, active-low reset.
- ch_en  in  N_CH  per-channel arbitration enable (configuration).
- ch_empty  in  N_CH  FIFO empty flags.
- ch_rd_en  out  N_CH  FIFO read enables; at most one bit high per cycle.
- ch_tdata  in  N_CH*DATA_WIDTH  FIFO read data; channel i at [i*DATA_WIDTH +: DATA_WIDTH]. Valid the cycle after that channel's rd_en.
- ch_tlast  in  N_CH  FIFO read tlast; same timing as ch_tdata.
- out_tvalid  out  1  output beat valid.
- out_tready  in  1  downstream accept.
- out_tdata  out  DATA_WIDTH  output beat data.
- out_tlast  out  1  last beat of packet.
- out_tdest  out  CH_W  source channel of the beat.
- busy  out  1  high while a packet is locked (state XFER).
- pkt_done  out  1  one-cycle pulse when a beat with tlast=1 is captured.

## Operation
- FSM states: IDLE and XFER. Reset state is IDLE.
- IDLE:
  - Candidates are channels with ch_en[i]=1 and ch_empty[i]=0.
  - The search starts at rr_ptr+1 and wraps modulo N_CH. The first candidate found becomes grant; rr_ptr <= grant; go to XFER.
  - No candidate: stay in IDLE.
  - No rd_en is issued in IDLE.
- rr_ptr resets to N_CH-1, so channel 0 has first priority after reset.
- XFER:
  - Issue ch_rd_en[grant] when all hold: !ch_empty[grant], no read in flight, and (!out_tvalid || out_tready).
  - In-flight flag sets on issue and clears on the following cycle, when the beat is captured.
  - Capture: out_tdata/out_tlast <= ch_tdata/ch_tlast of grant; out_tdest <= grant; out_tvalid <= 1.
  - If the captured tlast=1: pulse pkt_done and go to IDLE.
- The lock holds until tlast:
  - ch_en[grant] dropping mid-packet does not abort the packet.
  - ch_empty[grant]=1 mid-packet stalls reads only. The block stays in XFER, busy=1, and waits indefinitely.
- Output register: out_tvalid clears on accept (out_tvalid && out_tready) unless a capture occurs in the same cycle. Data is held stable while out_tvalid && !out_tready.
- A beat is never dropped or duplicated. The issue condition guarantees the output slot is free at capture.

## Timing
- Reset values: ch_rd_en=0, out_tvalid=0, out_tdata=0, out_tlast=0, out_tdest=0, busy=0, pkt_done=0, in-flight=0, rr_ptr=N_CH-1, state IDLE.
- Arbitration latency: candidate seen in IDLE at cycle t -> XFER at t+1 -> first rd_en at t+1 at the earliest.
- rd_en at cycle t -> capture at end of t+1 -> out_tvalid high at t+2.
- Peak throughput is 1 beat per 2 cycles; only one read is ever in flight.
- Inter-packet gap: tlast captured at end of t -> IDLE at t+1 -> next packet's first rd_en at t+2 at the earliest.
- pkt_done and the out_tvalid of the tlast beat rise in the same cycle.
- Simultaneous accept and capture: the output register is reloaded and out_tvalid stays 1.
- Reset asserted mid-packet: all state returns to reset values immediately.
  - The in-flight beat is discarded and the partial packet is lost.
  - The FIFOs share m_rst_n, so their read side resets too.

## Test plan
- Single packet: N_CH=4; ch0 holds 3 beats 0x11,0x22,0x33(tlast); out_tready=1. Required: output 0x11,0x22,0x33 with tdest=0, tlast only on 0x33, beats 2 cycles apart, one pkt_done pulse, busy falls the cycle after the 0x33 capture.
- Round-robin: ch0, ch1 and ch3 each hold two 2-beat packets; ch2 is empty. Required packet order by tdest: 0,1,3,0,1,3, with no interleaving of beats within a packet.
- Mask and empty: ch_en=4'b1101 with all channels non-empty. Required: ch1 is never granted. A packet whose FIFO runs empty mid-packet holds busy=1 with no rd_en; on refill it resumes on the same channel and no other channel is granted.
- Backpressure: out_tready=0 for 5 cycles during a 4-beat packet. Required: out_tdata/out_tlast/out_tdest stay stable and no rd_en is issued while the slot is full; all 4 beats arrive in order, none lost or duplicated.
- Mid-packet reset: assert m_rst_n=0 after the 2nd beat of a 5-beat packet from ch2. Required: all outputs at reset values on the same edge; after release, the first grant goes to the lowest-index non-empty enabled channel, starting from ch0.
